frame_buffer_reader: RTL and testbench

//  Consumer end of the frame-buffer-switcher buffer_port/buffer_vsync conduit. On each buffer_vsync rising edge, latch the buffer index.

---
 rtl/frame_buffer_pkg.sv | 24 ++
 rtl/frame_buffer_reader_fifo.sv | 61 ++++++
 rtl/frame_buffer_reader.sv | 216 +++++++++++++++++++++
 tb/tb_frame_buffer_reader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared types and sizing helpers for the frame buffer reader.
//   BUF_PORT_W   : width of the buffer index from the switcher
//   state_t      : reader FSM states
//   frame_pixels : pixels per frame
//   cnt_width    : bits needed to hold a count from 0 to n inclusive
package frame_buffer_pkg;

    localparam int unsigned BUF_PORT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/frame_buffer_reader_fifo.sv
// Synchronous show-ahead FIFO: o_data always presents the head entry.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   i_push, i_data    write strobe and data (ignored when full unless popping)
//   i_pop             remove head (ignored when empty)
//   o_data            head entry
//   o_empty           no entries
//   o_count           entries held, 0..DEPTH
module frame_buffer_reader_fifo
    import frame_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_push,
    input  logic [DATA_W-1:0]           i_data,
    input  logic                        i_pop,
    output logic [DATA_W-1:0]           o_data,
    output logic                        o_empty,
    output logic [cnt_width(DEPTH)-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_full;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset; only entries behind the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/frame_buffer_reader.sv
// Frame buffer reader: on each buffer_vsync rise, fetches the selected frame
// buffer over a pipelined Avalon-MM read master and streams it out as one
// Avalon-ST packet (SOP on first pixel, EOP on last).
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   buffer_port, buffer_vsync        buffer index and swap strobe from switcher
//   avm_*                            Avalon-MM read master
//   aso_*                            Avalon-ST pixel source (readyLatency 0)
//   busy                             frame start until EOP accepted
//   stat_frames, stat_dropped        only with FRAME_BUFFER_READER_STATS_EN
// Optional build macro: FRAME_BUFFER_READER_STATS_EN adds frame/drop counters.
module frame_buffer_reader
    import frame_buffer_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_W-1:0] BUF_STRIDE = ADDR_W'(32'h0010_0000),
    parameter int unsigned       FRAME_W    = 640,
    parameter int unsigned       FRAME_H    = 480,
    parameter int unsigned       FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUF_PORT_W-1:0] buffer_port,
    input  logic                  buffer_vsync,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic [DATA_W-1:0]     aso_data,
    output logic                  aso_valid,
    input  logic                  aso_ready,
    output logic                  aso_startofpacket,
    output logic                  aso_endofpacket,
    output logic                  busy
`ifdef FRAME_BUFFER_READER_STATS_EN
    ,
    output logic [15:0]           stat_frames,
    output logic [15:0]           stat_dropped
`endif
);

    localparam int unsigned       NPIX      = frame_pixels(FRAME_W, FRAME_H);
    localparam int unsigned       PIX_W     = cnt_width(NPIX);
    localparam int unsigned       CW        = cnt_width(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

    state_t                r_state;
    logic                  r_vsync_d;
    logic                  r_edge;
    logic [BUF_PORT_W-1:0] r_edge_port;
    logic                  r_pending;
    logic [BUF_PORT_W-1:0] r_pending_port;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_read;
    logic                  r_busy;
    logic [PIX_W-1:0]      r_rd_cnt;
    logic [PIX_W-1:0]      r_pix_cnt;
    logic [CW-1:0]         r_out;

    logic                  w_fifo_empty;
    logic [CW-1:0]         w_fifo_count;
    logic                  w_acc;
    logic                  w_rdv;
    logic                  w_pop;
    logic                  w_eop;
    logic                  w_eop_acc;
    logic                  w_last_acc;
    logic                  w_frame_done;
    logic                  w_start;
    logic                  w_pend;
    logic [BUF_PORT_W-1:0] w_start_port;
    logic [CW-1:0]         w_out_n;
    logic [CW-1:0]         w_cnt_n;
    logic                  w_credit_n;

    function automatic logic [ADDR_W-1:0] base_of(input logic [BUF_PORT_W-1:0] p);
        return BASE_ADDR + ADDR_W'(p) * BUF_STRIDE;
    endfunction

    frame_buffer_reader_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rdv),
        .i_data  (avm_readdata),
        .i_pop   (w_pop),
        .o_data  (aso_data),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_acc        = r_read & ~avm_waitrequest;
    // Returns with nothing outstanding are stray and dropped.
    assign w_rdv        = avm_readdatavalid & (r_out != '0);
    assign w_pop        = aso_valid & aso_ready;
    assign w_eop        = (r_pix_cnt == PIX_W'(NPIX - 1));
    assign w_eop_acc    = w_pop & w_eop;
    assign w_last_acc   = w_acc & (r_rd_cnt == PIX_W'(NPIX - 1));
    assign w_frame_done = (r_state == DRAIN) & w_eop_acc & (r_out == '0);

    // Credit for next cycle: outstanding plus buffered must leave room for one more.
    assign w_out_n    = r_out + CW'(w_acc) - CW'(w_rdv);
    assign w_cnt_n    = w_fifo_count + CW'(w_rdv) - CW'(w_pop);
    assign w_credit_n = ((CW+1)'(w_out_n) + (CW+1)'(w_cnt_n)) < (CW+1)'(FIFO_DEPTH);

    // A queued swap takes priority over an edge arriving on the EOP cycle.
    assign w_start      = ((r_state == IDLE) & r_edge) | (w_frame_done & (r_pending | r_edge));
    assign w_start_port = ((r_state != IDLE) & r_pending) ? r_pending_port : r_edge_port;
    assign w_pend       = r_edge & (r_state != IDLE) & ~w_frame_done;

    assign avm_address       = r_addr;
    assign avm_read          = r_read;
    assign busy              = r_busy;
    assign aso_valid         = ~w_fifo_empty;
    assign aso_startofpacket = aso_valid & (r_pix_cnt == '0);
    assign aso_endofpacket   = aso_valid & w_eop;

    // Registered vsync edge; port captured alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_d   <= 1'b0;
            r_edge      <= 1'b0;
            r_edge_port <= '0;
        end else begin
            r_vsync_d   <= buffer_vsync;
            r_edge      <= buffer_vsync & ~r_vsync_d;
            r_edge_port <= buffer_port;
        end
    end

    // Outstanding reads and output-side pixel position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out     <= '0;
            r_pix_cnt <= '0;
        end else begin
            r_out <= w_out_n;
            if (w_pop) r_pix_cnt <= w_eop ? '0 : r_pix_cnt + PIX_W'(1);
        end
    end

    // Reader FSM with address generator and request control.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_read         <= 1'b0;
            r_busy         <= 1'b0;
            r_rd_cnt       <= '0;
            r_pending      <= 1'b0;
            r_pending_port <= '0;
        end else begin
            if (w_start) begin
                r_state   <= READ;
                r_addr    <= base_of(w_start_port);
                r_read    <= 1'b1;
                r_busy    <= 1'b1;
                r_rd_cnt  <= '0;
                r_pending <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: ;
                    READ: begin
                        if (w_acc) begin
                            r_addr   <= r_addr + ADDR_STEP;
                            r_rd_cnt <= r_rd_cnt + PIX_W'(1);
                        end
                        if (w_last_acc) begin
                            r_state <= DRAIN;
                            r_read  <= 1'b0;
                        end else if (r_read & avm_waitrequest) begin
                            r_read <= 1'b1;
                        end else begin
                            r_read <= w_credit_n;
                        end
                    end
                    DRAIN: begin
                        if (w_frame_done) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
                if (w_pend) begin
                    r_pending      <= 1'b1;
                    r_pending_port <= r_edge_port;
                end
            end
        end
    end

`ifdef FRAME_BUFFER_READER_STATS_EN
    logic [15:0] r_stat_frames;
    logic [15:0] r_stat_dropped;

    assign stat_frames  = r_stat_frames;
    assign stat_dropped = r_stat_dropped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_frames  <= '0;
            r_stat_dropped <= '0;
        end else begin
            if (w_eop_acc)             r_stat_frames  <= r_stat_frames + 16'd1;
            if (w_pend & r_pending)    r_stat_dropped <= r_stat_dropped + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader with a 4x2 frame and 4-entry FIFO.
module tb_frame_buffer_reader;

    localparam int unsigned NPIX = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  buffer_port = 2'd0;
    logic        buffer_vsync = 1'b0;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [15:0] avm_readdata = 16'd0;
    logic        avm_readdatavalid = 1'b0;
    logic [15:0] aso_data;
    logic        aso_valid;
    logic        aso_ready = 1'b1;
    logic        aso_startofpacket;
    logic        aso_endofpacket;
    logic        busy;
`ifdef FRAME_BUFFER_READER_STATS_EN
    logic [15:0] stat_frames;
    logic [15:0] stat_dropped;
`endif

    always #5 clk = ~clk;

    frame_buffer_reader #(
        .ADDR_W     (32),
        .DATA_W     (16),
        .BASE_ADDR  (32'h0000_0000),
        .BUF_STRIDE (32'h0000_0100),
        .FRAME_W    (4),
        .FRAME_H    (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .buffer_port       (buffer_port),
        .buffer_vsync      (buffer_vsync),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .aso_data          (aso_data),
        .aso_valid         (aso_valid),
        .aso_ready         (aso_ready),
        .aso_startofpacket (aso_startofpacket),
        .aso_endofpacket   (aso_endofpacket),
        .busy              (busy)
`ifdef FRAME_BUFFER_READER_STATS_EN
        ,
        .stat_frames       (stat_frames),
        .stat_dropped      (stat_dropped)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Slave / sink controls set by the test sequence.
    int          lat        = 1;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_left = 0;
    int          rdy_mode   = 0;   // 0: always ready, 1: never ready, 2: random

    // Observations.
    logic [31:0] acc_q[$];
    logic [17:0] pix_q[$];         // {sop, eop, data}
    int          stall_seen = 0;
    int          bench_out  = 0;
    int          max_out    = 0;
    int          cyc        = 0;
    int          exp_frames = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rd_t;
    rd_t rd_q[$];

    logic        s_acc  = 1'b0;
    logic [31:0] s_addr = 32'd0;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[15:0] ^ 16'hC3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory slave and pixel sink: observe at negedge, drive just after posedge.
    always begin : slave_sink
        @(negedge clk);
        if (reset) begin
            rd_q.delete();
            bench_out = 0;
            s_acc     = 1'b0;
        end else begin
            s_acc  = avm_read & ~avm_waitrequest;
            s_addr = avm_address;
            if (avm_read && avm_address == stall_addr) stall_seen++;
            if (s_acc) acc_q.push_back(avm_address);
            if (aso_valid && aso_ready)
                pix_q.push_back({aso_startofpacket, aso_endofpacket, aso_data});
            bench_out = bench_out + (s_acc ? 1 : 0) - ((avm_readdatavalid && bench_out > 0) ? 1 : 0);
            if (bench_out > max_out) max_out = bench_out;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (reset) begin
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b0;
        end else begin
            if (s_acc) rd_q.push_back('{s_addr, cyc + lat - 1});
            if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = mem_word(rd_q[0].addr);
                void'(rd_q.pop_front());
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata      = 16'd0;
            end
            if (avm_read && avm_address == stall_addr && stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                avm_waitrequest = 1'b0;
            end
            case (rdy_mode)
                0:       aso_ready = 1'b1;
                1:       aso_ready = 1'b0;
                default: aso_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Pulse vsync from idle and check the two-cycle request latency.
    task automatic start_frame(input logic [1:0] p);
        acc_q.delete();
        pix_q.delete();
        stall_seen  = 0;
        max_out     = 0;
        buffer_port = p;
        buffer_vsync = 1'b1;
        @(posedge clk); #1;
        buffer_vsync = 1'b0;
        check("read_low_1cyc", {31'd0, avm_read}, 32'd0);
        @(posedge clk); #1;
        check("read_high_2cyc", {31'd0, avm_read}, 32'd1);
        check("busy_at_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic pulse_vsync(input logic [1:0] p);
        buffer_port  = p;
        buffer_vsync = 1'b1;
        @(posedge clk); #1;
        buffer_vsync = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int exp_pix);
        int i;
        i = 0;
        while (i < 3000 && !(pix_q.size() >= exp_pix && !busy)) begin
            @(negedge clk);
            i++;
        end
        check("frame_done", (i < 3000) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input logic [31:0] base, input int off);
        for (int k = 0; k < int'(NPIX); k++) begin
            logic [31:0] ea;
            logic [31:0] a;
            logic [31:0] px;
            ea = base + 32'(2 * k);
            a  = (off + k < acc_q.size()) ? acc_q[off + k] : 32'hDEAD_BEEF;
            px = (off + k < pix_q.size()) ? {14'd0, pix_q[off + k]} : 32'hDEAD_BEEF;
            check("read_addr", a, ea);
            check("pixel_sop_eop_data", px, {14'd0, (k == 0), (k == 7), mem_word(ea)});
        end
    endtask

    typedef struct {
        logic [1:0]  port;
        int          lat;
        logic [31:0] stall_addr;
        int          stall_n;
        int          rdy;
        logic [31:0] base;
    } vec_t;

    vec_t vecs[4];

    initial begin : test
        vecs[0] = '{2'd2, 1, 32'hFFFF_FFFF, 0, 0, 32'h200};
        vecs[1] = '{2'd2, 1, 32'h0000_0206, 3, 0, 32'h200};
        vecs[2] = '{2'd0, 5, 32'hFFFF_FFFF, 0, 2, 32'h000};
        vecs[3] = '{2'd3, 5, 32'h0000_0304, 2, 2, 32'h300};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_avm_read", {31'd0, avm_read}, 32'd0);
        check("rst_avm_address", avm_address, 32'd0);
        check("rst_aso_valid", {31'd0, aso_valid}, 32'd0);
        check("rst_sop", {31'd0, aso_startofpacket}, 32'd0);
        check("rst_eop", {31'd0, aso_endofpacket}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Table-driven frames.
        for (int v = 0; v < 4; v++) begin
            lat        = vecs[v].lat;
            stall_addr = vecs[v].stall_addr;
            stall_left = vecs[v].stall_n;
            rdy_mode   = vecs[v].rdy;
            start_frame(vecs[v].port);
            wait_done(NPIX);
            exp_frames++;
            check("n_reads", 32'(acc_q.size()), NPIX);
            check("n_pixels", 32'(pix_q.size()), NPIX);
            check_frame(vecs[v].base, 0);
            if (vecs[v].stall_n > 0)
                check("stall_addr_cycles", 32'(stall_seen), 32'(vecs[v].stall_n + 1));
            check("max_outstanding_le4", (max_out <= 4) ? 32'd1 : 32'd0, 32'd1);
`ifdef FRAME_BUFFER_READER_STATS_EN
            check("stat_frames", {16'd0, stat_frames}, 32'(exp_frames));
`endif
        end
        stall_addr = 32'hFFFF_FFFF;
        stall_left = 0;

        // Sink stalled: credits limit requests to the FIFO depth.
        lat      = 1;
        rdy_mode = 1;
        start_frame(2'd1);
        repeat (20) @(posedge clk);
        #1;
        check("credit_reads", 32'(acc_q.size()), 32'd4);
        check("credit_read_low", {31'd0, avm_read}, 32'd0);
        check("credit_valid", {31'd0, aso_valid}, 32'd1);
        check("credit_sop", {31'd0, aso_startofpacket}, 32'd1);
        check("credit_no_pop", 32'(pix_q.size()), 32'd0);
        rdy_mode = 0;
        wait_done(NPIX);
        exp_frames++;
        check_frame(32'h100, 0);

        // Swaps while busy: last one wins, frame in flight completes.
        lat = 5;
        start_frame(2'd2);
        pulse_vsync(2'd1);
        pulse_vsync(2'd3);
        check("busy_during_pending", {31'd0, busy}, 32'd1);
        wait_done(2 * NPIX);
        exp_frames += 2;
        repeat (10) @(posedge clk);
        #1;
        check("pending_n_reads", 32'(acc_q.size()), 32'd16);
        check_frame(32'h200, 0);
        check_frame(32'h300, 8);
`ifdef FRAME_BUFFER_READER_STATS_EN
        check("stat_dropped", {16'd0, stat_dropped}, 32'd1);
        check("stat_frames_pending", {16'd0, stat_frames}, 32'(exp_frames));
`endif

        // Reset mid-frame.
        lat = 1;
        start_frame(2'd1);
        begin
            int i;
            i = 0;
            while (i < 500 && pix_q.size() < 5) begin
                @(negedge clk);
                i++;
            end
            check("reach_5_pixels", (i < 500) ? 32'd1 : 32'd0, 32'd1);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("mid_rst_read", {31'd0, avm_read}, 32'd0);
        check("mid_rst_valid", {31'd0, aso_valid}, 32'd0);
        check("mid_rst_eop", {31'd0, aso_endofpacket}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
`ifdef FRAME_BUFFER_READER_STATS_EN
        check("mid_rst_stat_frames", {16'd0, stat_frames}, 32'd0);
        check("mid_rst_stat_dropped", {16'd0, stat_dropped}, 32'd0);
`endif
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        exp_frames = 0;
        @(posedge clk); #1;
        start_frame(2'd0);
        wait_done(NPIX);
        exp_frames++;
        check("post_rst_n_pixels", 32'(pix_q.size()), NPIX);
        check_frame(32'h000, 0);
`ifdef FRAME_BUFFER_READER_STATS_EN
        check("post_rst_stat_frames", {16'd0, stat_frames}, 32'(exp_frames));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
